// File: rtl/stereo_pkg.sv
// Shared widths, grouping constant and search FSM encoding for the stereo block.
package stereo_pkg;

  localparam int unsigned WS_W       = 14;
  localparam int unsigned DISP_W     = 6;
  localparam int unsigned GROUP_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } search_state_t;

endpackage

// File: rtl/tag_pipe.sv
// Valid-token shift pipe mirroring the compare-tree latency; one bit per in-flight group.
module tag_pipe #(
  parameter int unsigned TREE_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic tok_in,
  output logic tok_out,
  output logic last_out
);

  logic [TREE_LAT-1:0] pipe;
  logic [TREE_LAT-1:0] exit_only;

  // Shift tokens toward the exit stage; reset drops every in-flight token.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= tok_in;
      for (int unsigned i = 1; i < TREE_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Pattern for "only the exiting stage holds a token".
  always_comb begin
    exit_only             = '0;
    exit_only[TREE_LAT-1] = 1'b1;
  end

  assign tok_out  = pipe[TREE_LAT-1];
  assign last_out = (pipe == exit_only);

endmodule

// File: rtl/disparity_search_ctrl.sv
// Per-pixel disparity search: issues candidate groups to the window-sum engine,
// tracks them through the compare tree and keeps the running minimum.
module disparity_search_ctrl
  import stereo_pkg::*;
#(
  parameter int unsigned NUM_DISP = 64,
  parameter int unsigned TREE_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              grp_valid,
  input  logic              grp_ready,
  output logic [DISP_W-1:0] grp_base,
  output logic [DISP_W-1:0] tree_disp_1,
  output logic [DISP_W-1:0] tree_disp_2,
  output logic [DISP_W-1:0] tree_disp_3,
  output logic [DISP_W-1:0] tree_disp_4,
  input  logic [DISP_W-1:0] tree_disparity,
  input  logic [WS_W-1:0]   tree_window_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DISP_W-1:0] out_disparity,
  output logic [WS_W-1:0]   out_min_sum
);

  localparam logic [DISP_W-1:0] LAST_BASE = DISP_W'(NUM_DISP - GROUP_SIZE);
  localparam logic [DISP_W-1:0] GRP_STEP  = DISP_W'(GROUP_SIZE);

  search_state_t     state, state_nx;
  logic [DISP_W-1:0] grp_cnt;
  logic [DISP_W-1:0] best_disp;
  logic [WS_W-1:0]   best_sum;
  logic              have_best;
  logic              accept, issue, in_issue;
  logic              tok_exit, last_exit;

  tag_pipe #(.TREE_LAT(TREE_LAT)) u_tag_pipe (
    .clock    (clock),
    .reset    (reset),
    .tok_in   (issue),
    .tok_out  (tok_exit),
    .last_out (last_exit)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    pix_ready = 1'b0;
    grp_valid = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        grp_valid = 1'b1;
        if (grp_ready && (grp_cnt == LAST_BASE)) state_nx = DRAIN;
      end
      DRAIN: begin
        // Leave once the final in-flight token is being sampled this cycle.
        if (tok_exit && last_exit) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept   = pix_valid && pix_ready;
  assign issue    = grp_valid && grp_ready;
  assign in_issue = (state == ISSUE);

  assign grp_base    = in_issue ? grp_cnt : '0;
  assign tree_disp_1 = in_issue ? grp_cnt : '0;
  assign tree_disp_2 = in_issue ? grp_cnt + DISP_W'(1) : '0;
  assign tree_disp_3 = in_issue ? grp_cnt + DISP_W'(2) : '0;
  assign tree_disp_4 = in_issue ? grp_cnt + DISP_W'(3) : '0;

  // Group counter: restarts per pixel, advances only on an accepted issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       grp_cnt <= '0;
    else if (accept) grp_cnt <= '0;
    else if (issue)  grp_cnt <= grp_cnt + GRP_STEP;
  end

  // Running minimum; strict less-than keeps the lower disparity on ties
  // because groups arrive in ascending order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      have_best <= 1'b0;
      best_disp <= '0;
      best_sum  <= '1;
    end else if (accept) begin
      have_best <= 1'b0;
    end else if (tok_exit && (!have_best || (tree_window_sum < best_sum))) begin
      have_best <= 1'b1;
      best_disp <= tree_disparity;
      best_sum  <= tree_window_sum;
    end
  end

  assign out_disparity = best_disp;
  assign out_min_sum   = best_sum;

endmodule

// File: tb/tb_disparity_search_ctrl.sv
// Directed bench for disparity_search_ctrl with a behavioural window-sum/compare-tree engine.
module tb_disparity_search_ctrl;
  import stereo_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              pix_valid = 1'b0, pix_ready;
  logic              grp_valid, grp_ready = 1'b1;
  logic [DISP_W-1:0] grp_base, tree_disp_1, tree_disp_2, tree_disp_3, tree_disp_4;
  logic [DISP_W-1:0] tree_disparity, out_disparity;
  logic [WS_W-1:0]   tree_window_sum, out_min_sum;
  logic              out_valid, out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [WS_W-1:0]   sums [0:63];
  logic              s0_v = 1'b0, s1_v = 1'b0;
  logic [DISP_W-1:0] s0_d, s1_d;
  logic [WS_W-1:0]   s0_s, s1_s;

  disparity_search_ctrl #(.NUM_DISP(64), .TREE_LAT(2)) dut (
    .clock(clock), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_base(grp_base),
    .tree_disp_1(tree_disp_1), .tree_disp_2(tree_disp_2),
    .tree_disp_3(tree_disp_3), .tree_disp_4(tree_disp_4),
    .tree_disparity(tree_disparity), .tree_window_sum(tree_window_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_disparity(out_disparity), .out_min_sum(out_min_sum)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Engine model: minimum of four candidates, lowest disparity wins ties.
  function automatic logic [19:0] engine_min(input logic [5:0] base);
    logic [5:0]  bd;
    logic [13:0] bs;
    bd = base;
    bs = sums[base];
    for (int k = 1; k < 4; k++) begin
      if (sums[int'(base) + k] < bs) begin
        bs = sums[int'(base) + k];
        bd = base + 6'(k);
      end
    end
    return {bd, bs};
  endfunction

  // Two-stage tree latency; deliberately not reset so stale results keep flowing.
  always @(posedge clock) begin
    s0_v <= grp_valid && grp_ready;
    {s0_d, s0_s} <= engine_min(grp_base);
    s1_v <= s0_v;
    s1_d <= s0_d;
    s1_s <= s0_s;
  end
  // Idle tree output carries an attractive junk result to expose stray sampling.
  assign tree_disparity  = s1_v ? s1_d : 6'd63;
  assign tree_window_sum = s1_v ? s1_s : 14'd0;

  task automatic fill_sums(input int base_val);
    for (int d = 0; d < 64; d++) sums[d] = 14'(base_val + d);
  endtask

  task automatic run_pixel(input bit same_cycle, input int sa, input int sb,
                           output int acc, output int lat, output int n_iss,
                           output int order_err, output int idle_err);
    int bound;
    int stall_left;
    logic [5:0] exp_base;
    if (!same_cycle) @(negedge clock);
    pix_valid = 1'b1; grp_ready = 1'b1; out_ready = 1'b0;
    bound = 0;
    while (!pix_ready && bound < 50) begin @(negedge clock); bound++; end
    acc = cyc;
    lat = -1; n_iss = 0; order_err = 0; idle_err = 0; stall_left = 0; exp_base = '0;
    @(negedge clock);
    pix_valid = 1'b0;
    bound = 0;
    while (!out_valid && bound < 200) begin
      if (stall_left > 0) begin grp_ready = 1'b0; stall_left--; end
      else grp_ready = 1'b1;
      #1;
      if (grp_valid) begin
        if (grp_base !== exp_base || tree_disp_1 !== exp_base ||
            tree_disp_2 !== exp_base + 6'd1 || tree_disp_3 !== exp_base + 6'd2 ||
            tree_disp_4 !== exp_base + 6'd3) order_err++;
        if (grp_ready) begin
          n_iss++;
          exp_base = exp_base + 6'd4;
          if (n_iss == sa || n_iss == sb) stall_left = 3;
        end
      end else if (grp_base !== 6'd0 || tree_disp_1 !== 6'd0 || tree_disp_2 !== 6'd0 ||
                   tree_disp_3 !== 6'd0 || tree_disp_4 !== 6'd0) begin
        idle_err++;
      end
      @(negedge clock);
      bound++;
    end
    if (out_valid) lat = cyc - acc;
    grp_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_valid = 1'b0; out_ready = 1'b0; grp_ready = 1'b1;
    fill_sums(14'h3FFF - 64);
    repeat (3) @(negedge clock);
    n_vec++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
    n_vec++; if (grp_valid !== 1'b0) begin n_err++; $display("FAIL reset_grp_valid: got %b want 0", grp_valid); end
    n_vec++; if (grp_base !== 6'd0) begin n_err++; $display("FAIL reset_grp_base: got %0d want 0", grp_base); end
    n_vec++; if (tree_disp_1 !== 6'd0) begin n_err++; $display("FAIL reset_tree_disp_1: got %0d want 0", tree_disp_1); end
    n_vec++; if (tree_disp_4 !== 6'd0) begin n_err++; $display("FAIL reset_tree_disp_4: got %0d want 0", tree_disp_4); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_disparity !== 6'd0) begin n_err++; $display("FAIL reset_out_disparity: got %0d want 0", out_disparity); end
    n_vec++; if (out_min_sum !== 14'h3FFF) begin n_err++; $display("FAIL reset_out_min_sum: got %h want 3fff", out_min_sum); end
    reset = 1'b0;
  endtask

  task automatic test_unimodal();
    int acc, lat, n_iss, oe, ie;
    fill_sums(500); sums[37] = 14'd100;
    run_pixel(1'b0, 0, 0, acc, lat, n_iss, oe, ie);
    n_vec++; if (lat !== 19) begin n_err++; $display("FAIL uni_latency: got %0d want 19", lat); end
    n_vec++; if (n_iss !== 16) begin n_err++; $display("FAIL uni_issues: got %0d want 16", n_iss); end
    n_vec++; if (oe !== 0) begin n_err++; $display("FAIL uni_group_order: got %0d bad cycles want 0", oe); end
    n_vec++; if (ie !== 0) begin n_err++; $display("FAIL uni_idle_tags: got %0d bad cycles want 0", ie); end
    n_vec++; if (out_disparity !== 6'd37) begin n_err++; $display("FAIL uni_disparity: got %0d want 37", out_disparity); end
    n_vec++; if (out_min_sum !== 14'd100) begin n_err++; $display("FAIL uni_min_sum: got %0d want 100", out_min_sum); end
    out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL uni_out_valid_after_hs: got %b want 0", out_valid); end
    n_vec++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL uni_pix_ready_after_hs: got %b want 1", pix_ready); end
  endtask

  task automatic test_tie();
    int acc, lat, n_iss, oe, ie;
    fill_sums(300); sums[5] = 14'd200; sums[40] = 14'd200;
    run_pixel(1'b0, 0, 0, acc, lat, n_iss, oe, ie);
    n_vec++; if (out_disparity !== 6'd5) begin n_err++; $display("FAIL tie_disparity: got %0d want 5", out_disparity); end
    n_vec++; if (out_min_sum !== 14'd200) begin n_err++; $display("FAIL tie_min_sum: got %0d want 200", out_min_sum); end
    out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
  endtask

  task automatic test_stalls();
    int acc, lat, n_iss, oe, ie;
    fill_sums(500); sums[37] = 14'd100;
    run_pixel(1'b0, 2, 9, acc, lat, n_iss, oe, ie);
    n_vec++; if (lat !== 25) begin n_err++; $display("FAIL stall_latency: got %0d want 25", lat); end
    n_vec++; if (n_iss !== 16) begin n_err++; $display("FAIL stall_issues: got %0d want 16", n_iss); end
    n_vec++; if (oe !== 0) begin n_err++; $display("FAIL stall_base_stable: got %0d bad cycles want 0", oe); end
    n_vec++; if (out_disparity !== 6'd37) begin n_err++; $display("FAIL stall_disparity: got %0d want 37", out_disparity); end
    n_vec++; if (out_min_sum !== 14'd100) begin n_err++; $display("FAIL stall_min_sum: got %0d want 100", out_min_sum); end
    out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
  endtask

  task automatic test_backpressure_back_to_back();
    int acc, lat, n_iss, oe, ie, hs;
    fill_sums(1000); sums[63] = 14'd7;
    run_pixel(1'b0, 0, 0, acc, lat, n_iss, oe, ie);
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_vec++; if (out_disparity !== 6'd63) begin n_err++; $display("FAIL bp_disparity[%0d]: got %0d want 63", i, out_disparity); end
      n_vec++; if (out_min_sum !== 14'd7) begin n_err++; $display("FAIL bp_min_sum[%0d]: got %0d want 7", i, out_min_sum); end
      n_vec++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL bp_pix_ready[%0d]: got %b want 0", i, pix_ready); end
      @(negedge clock);
    end
    fill_sums(14'h3FFF - 64);
    for (int d = 0; d < 64; d++) sums[d] = 14'h3FFF;
    out_ready = 1'b1; pix_valid = 1'b1; hs = cyc;
    #1;
    n_vec++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_accept_in_hs: got %b want 0", pix_ready); end
    @(negedge clock); out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_out_valid_after_hs: got %b want 0", out_valid); end
    run_pixel(1'b1, 0, 0, acc, lat, n_iss, oe, ie);
    n_vec++; if (acc !== hs + 1) begin n_err++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc, hs + 1); end
    n_vec++; if (lat !== 19) begin n_err++; $display("FAIL b2b_latency: got %0d want 19", lat); end
    n_vec++; if (out_disparity !== 6'd0) begin n_err++; $display("FAIL allmax_disparity: got %0d want 0", out_disparity); end
    n_vec++; if (out_min_sum !== 14'h3FFF) begin n_err++; $display("FAIL allmax_min_sum: got %h want 3fff", out_min_sum); end
    out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_search();
    int acc, lat, n_iss, oe, ie, bound, start;
    fill_sums(900); sums[25] = 14'd1;
    @(negedge clock);
    pix_valid = 1'b1; grp_ready = 1'b1;
    bound = 0;
    while (!pix_ready && bound < 50) begin @(negedge clock); bound++; end
    start = cyc;
    @(negedge clock); pix_valid = 1'b0;
    repeat (7) @(negedge clock);
    // Cycle 8 of the search: new pixel data, short reset pulse, then re-request.
    fill_sums(900); sums[50] = 14'd100;
    n_vec++; if (cyc !== start + 8) begin n_err++; $display("FAIL rst_mid_cycle: got %0d want %0d", cyc - start, 8); end
    reset = 1'b1; pix_valid = 1'b1;
    #1;
    n_vec++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_pix_ready: got %b want 1", pix_ready); end
    n_vec++; if (grp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_grp_valid: got %b want 0", grp_valid); end
    n_vec++; if (grp_base !== 6'd0) begin n_err++; $display("FAIL rst_mid_grp_base: got %0d want 0", grp_base); end
    n_vec++; if (tree_disp_3 !== 6'd0) begin n_err++; $display("FAIL rst_mid_tree_disp_3: got %0d want 0", tree_disp_3); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_disparity !== 6'd0) begin n_err++; $display("FAIL rst_mid_out_disparity: got %0d want 0", out_disparity); end
    n_vec++; if (out_min_sum !== 14'h3FFF) begin n_err++; $display("FAIL rst_mid_out_min_sum: got %h want 3fff", out_min_sum); end
    #1 reset = 1'b0;
    run_pixel(1'b1, 0, 0, acc, lat, n_iss, oe, ie);
    n_vec++; if (lat !== 19) begin n_err++; $display("FAIL rst_new_latency: got %0d want 19", lat); end
    n_vec++; if (n_iss !== 16) begin n_err++; $display("FAIL rst_new_issues: got %0d want 16", n_iss); end
    n_vec++; if (out_disparity !== 6'd50) begin n_err++; $display("FAIL rst_new_disparity: got %0d want 50", out_disparity); end
    n_vec++; if (out_min_sum !== 14'd100) begin n_err++; $display("FAIL rst_new_min_sum: got %0d want 100", out_min_sum); end
    out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unimodal();
    test_tie();
    test_stalls();
    test_backpressure_back_to_back();
    test_reset_mid_search();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule
